// File: rtl/sram_stream_reader_if.sv
// Avalon-MM read master toward the SRAM bridge plus the streaming output
// of sram_stream_reader, bundled as one interface.
interface sram_stream_reader_if;
    logic        m_chipselect_n;
    logic        m_read_n;
    logic        m_write_n;
    logic [1:0]  m_byteenable_n;
    logic [19:0] m_address;
    logic [15:0] m_readdata;
    logic [15:0] st_data;
    logic        st_valid;
    logic        st_ready;

    modport master (
        output m_chipselect_n, m_read_n, m_write_n, m_byteenable_n, m_address,
        output st_data, st_valid,
        input  m_readdata, st_ready
    );

    modport slave (
        input  m_chipselect_n, m_read_n, m_write_n, m_byteenable_n, m_address,
        input  st_data, st_valid,
        output m_readdata, st_ready
    );
endinterface

// File: rtl/sram_stream_reader.sv
// Streams a block of SRAM words through a small FWFT FIFO onto a ready/valid port.
// Optional macro SRAM_STREAM_READER_WRAP_EN: loop over the block until stop.
module sram_stream_reader #(
    parameter int WAIT_CYCLES = 1,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [19:0]          base_addr,
    input  logic [19:0]          word_count,
    output logic                 busy,
    output logic                 done,
    sram_stream_reader_if.master bus
);
    localparam int                PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]        WAIT_LAST = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, READ, PAUSE, DONE} state_t;

    state_t             state, state_next;
    logic [19:0]        addr, remaining;
    logic [3:0]         wait_cnt;
    logic               stop_seen;
    logic               read_active, accept, read_last, end_xfer;

    logic [15:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   mem_count, occupancy, occ_after;
    logic               out_valid;
    logic [15:0]        out_data;
    logic               push, pop, load, fifo_full;

    assign read_last = (state == READ) && (wait_cnt == WAIT_LAST);
    assign push      = read_last;
    assign pop       = out_valid && bus.st_ready;
    // The output register refills from memory one cycle after a push, which
    // is where the extra cycle of start-to-valid latency comes from.
    assign load      = (mem_count != '0) && (!out_valid || bus.st_ready);
    assign occupancy = mem_count + CNT_W'(out_valid);
    assign fifo_full = (occupancy == DEPTH_C);
    assign occ_after = occupancy + CNT_W'(push) - CNT_W'(pop);

`ifdef SRAM_STREAM_READER_WRAP_EN
    assign end_xfer = stop || stop_seen;
`else
    assign end_xfer = stop || stop_seen || (remaining == 20'd1);
`endif

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: every register update uses <= so all flops sample pre-edge values together.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case leaves an output unassigned (no latches).
        state_next  = state;
        busy        = 1'b1;
        done        = 1'b0;
        read_active = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (word_count == 20'd0) begin
                        state_next = DONE;
                    end else begin
                        accept     = 1'b1;
                        state_next = fifo_full ? PAUSE : READ;
                    end
                end
            end
            READ: begin
                read_active = 1'b1;
                if (read_last) begin
                    if (end_xfer)                  state_next = DONE;
                    else if (occ_after == DEPTH_C) state_next = PAUSE;
                    else                           state_next = READ;
                end
            end
            PAUSE: begin
                if (stop)            state_next = DONE;
                else if (!fifo_full) state_next = READ;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.m_chipselect_n = !read_active;
    assign bus.m_read_n       = !read_active;
    assign bus.m_write_n      = 1'b1;
    assign bus.m_byteenable_n = 2'b00;
    assign bus.m_address      = addr;

`ifdef SRAM_STREAM_READER_WRAP_EN
    logic [19:0] base_q, count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q  <= '0;
            count_q <= '0;
        end else if (accept) begin
            base_q  <= base_addr;
            count_q <= word_count;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr      <= '0;
            remaining <= '0;
            wait_cnt  <= '0;
            stop_seen <= 1'b0;
        end else begin
            if (accept) begin
                addr      <= base_addr;
                remaining <= word_count;
            end else if (push) begin
`ifdef SRAM_STREAM_READER_WRAP_EN
                if (remaining == 20'd1) begin
                    addr      <= base_q;
                    remaining <= count_q;
                end else begin
                    addr      <= addr + 20'd1;
                    remaining <= remaining - 20'd1;
                end
`else
                addr      <= addr + 20'd1;
                remaining <= remaining - 20'd1;
`endif
            end
            wait_cnt  <= (state == READ && !read_last) ? wait_cnt + 4'd1 : 4'd0;
            // A stop during an access is held until that access completes.
            stop_seen <= (state == READ) && !read_last && (stop_seen || stop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (load) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                out_data <= mem[rd_ptr];
            end
            mem_count <= mem_count + CNT_W'(push) - CNT_W'(load);
            if (load)     out_valid <= 1'b1;
            else if (pop) out_valid <= 1'b0;
        end
    end

    // NOTE: storage array has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.m_readdata;
    end

    assign bus.st_valid = out_valid;
    assign bus.st_data  = out_data;
endmodule
